uart_ddr2_cmd_parser: RTL and testbench
=======================================

Name: uart_ddr2_cmd_parser

Overview:
- Sits directly downstream of the UART receiver inside top_uart and upstream of the DDR2 controller user port.
- Assembles received bytes into host commands and presents each complete command on a valid/ready handshake:
  - write: 0x01, 4 address bytes, 16 data bytes, 0xFF
  - read: 0x02, 4 address bytes, 0xFF
- Flags malformed frames and stalled frames.

Parameters:
- ADDR_WIDTH, 26, width of the DDR2 byte-group address (ROW 13 + COL 10 + BA 3).
- DATA_BYTES, 16, payload bytes per write frame (one 8-beat x 16-bit burst).
- TIMEOUT_CYC, 200000, maximum sys_clk cycles allowed between bytes inside a frame.
- OP_WR, 8'h01, write opcode.
- OP_RD, 8'h02, read opcode.
- TAIL_BYTE, 8'hFF, frame terminator.

Ports:
- sys_clk  in  1  system clock, 100 MHz.
- sys_rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte from the UART receiver.
- rx_valid  in  1  one-cycle strobe: rx_data is valid.
- cmd_valid  out  1  command available.
- cmd_ready  in  1  controller accepts the command.
- cmd_is_wr  out  1  1 = write, 0 = read.
- cmd_addr  out  ADDR_WIDTH  command address.
- cmd_wdata  out  8*DATA_BYTES  write payload. Byte k of the payload sits at bits [8k+7:8k].
- frame_err  out  1  one-cycle pulse on any dropped frame.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clock and reset: one clock, sys_clk. Reset is asynchronous and active-low, on sys_rst_n.
- Reset values: all outputs are 0, the FSM is in IDLE, and all counters are 0.
- IDLE:
  - rx_valid with rx_data == OP_WR: latch is_wr=1, go to ADDR.
  - rx_valid with rx_data == OP_RD: latch is_wr=0, go to ADDR.
  - Any other byte: pulse frame_err, stay in IDLE.
- ADDR:
  - Collect 4 bytes, MSB first, into a 32-bit shift register.
  - cmd_addr is the low ADDR_WIDTH bits; upper bits are discarded silently.
  - After the 4th byte, go to DATA if is_wr, otherwise go to TAIL.
- DATA:
  - Byte index k counts 0..DATA_BYTES-1; each byte is written to its slot in the payload register.
  - After byte DATA_BYTES-1, go to TAIL.
- TAIL:
  - Next byte == TAIL_BYTE: go to ISSUE.
  - Any other value: pulse frame_err, go to IDLE. Nothing is issued.
- ISSUE:
  - cmd_valid is registered and rises in the cycle after the terminator byte is accepted.
  - cmd_valid, cmd_is_wr, cmd_addr and cmd_wdata stay stable until cmd_valid && cmd_ready is sampled high.
  - On that handshake edge cmd_valid drops to 0 and the FSM returns to IDLE.
  - cmd_ready is ignored when cmd_valid is low.
  - Bytes that arrive during ISSUE are dropped, and each one pulses frame_err.
- Read commands: cmd_wdata holds its last value and is don't-care.
- Timeout:
  - A 32-bit gap counter clears on every rx_valid and on entry to ADDR.
  - It increments every cycle in ADDR, DATA and TAIL.
  - When it reaches TIMEOUT_CYC-1, pulse frame_err and go to IDLE.
  - Timeout is not applied in ISSUE; back-pressure there is unbounded.
- Simultaneous events: if rx_valid arrives in the same cycle the timeout fires, the byte wins and the counter clears.
- Reset mid-frame: partial state is discarded immediately. No command and no frame_err is produced.

Decomposition:
- Shared package ddr2_uart_pkg holds:
  - OP_WR, OP_RD, TAIL_BYTE
  - the FSM state encoding (IDLE, ADDR, DATA, TAIL, ISSUE)
  - ADDR_WIDTH and the payload width
- No sub-module. A single FSM plus shift and payload registers is sufficient.

Test Plan:
1. Write frame: bytes 01 00 00 00 00 11 22 33 44 55 66 77 88 99 AA BB CC DD EE 11 22 FF, cmd_ready=1.
   Expect one cmd_valid pulse with cmd_is_wr=1, cmd_addr=0, and cmd_wdata=128'h2211EEDDCCBBAA998877665544332211. No frame_err.
2. Read frame: bytes 02 00 01 23 45 FF.
   Expect cmd_valid, cmd_is_wr=0, cmd_addr=26'h0012345.
   Hold cmd_ready=0 for 10 cycles: outputs stay stable and busy=1. Raise cmd_ready: cmd_valid falls on the next edge.
3. Bad terminator: read frame ending in 0xFE.
   Expect a frame_err pulse and no cmd_valid. A following valid read frame then issues normally.
4. Timeout: send 01 00 00, then stall TIMEOUT_CYC cycles.
   Expect a frame_err pulse and busy=0. A subsequent full write frame is accepted.
5. Unknown opcode 0x55, then a byte sent during ISSUE with cmd_ready=0.
   Expect a frame_err pulse for each. The pending command is unchanged.
6. Assert sys_rst_n=0 mid-DATA (after byte 10), then release.
   Expect all outputs 0 immediately, no command, and no frame_err. The next full frame parses correctly.

Source files
------------

// File: rtl/ddr2_uart_pkg.sv
// ddr2_uart_pkg: opcodes, frame constants and parser state encoding shared by the UART/DDR2 command path
package ddr2_uart_pkg;
  localparam int ADDR_WIDTH = 26;
  localparam int DATA_BYTES = 16;
  localparam int WDATA_W    = 8 * DATA_BYTES;
  localparam logic [7:0] OP_WR     = 8'h01;
  localparam logic [7:0] OP_RD     = 8'h02;
  localparam logic [7:0] TAIL_BYTE = 8'hFF;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_TAIL,
    ST_ISSUE
  } state_t;
endpackage

// File: rtl/uart_ddr2_cmd_parser.sv
// uart_ddr2_cmd_parser: assembles UART bytes into DDR2 read/write commands on a valid/ready handshake
module uart_ddr2_cmd_parser
  import ddr2_uart_pkg::*;
#(
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic                  cmd_is_wr,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [WDATA_W-1:0]    cmd_wdata,
  output logic                  frame_err,
  output logic                  busy
);
  localparam int CW = (DATA_BYTES > 4) ? $clog2(DATA_BYTES) : 2;
  state_t                r_state;
  state_t                w_next;
  logic                  w_err;
  logic                  w_frame;
  logic                  w_to;
  logic                  r_err;
  logic                  r_is_wr;
  logic [CW-1:0]         r_cnt;
  logic [31:0]           r_gap;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WDATA_W-1:0]    r_wdata;
  assign cmd_valid = (r_state == ST_ISSUE);
  assign busy      = (r_state != ST_IDLE);
  assign cmd_is_wr = r_is_wr;
  assign cmd_addr  = r_addr;
  assign cmd_wdata = r_wdata;
  assign frame_err = r_err;
  // Next-state decode; an arriving byte always beats a timeout in the same cycle
  always_comb begin
    w_next  = r_state;
    w_err   = 1'b0;
    w_frame = (r_state == ST_ADDR) || (r_state == ST_DATA) || (r_state == ST_TAIL);
    w_to    = w_frame && !rx_valid && (r_gap == 32'(TIMEOUT_CYC - 1));
    case (r_state)
      ST_IDLE: begin
        if (rx_valid) begin
          w_next = (rx_data == OP_WR || rx_data == OP_RD) ? ST_ADDR : ST_IDLE;
          w_err  = !(rx_data == OP_WR || rx_data == OP_RD);
        end
      end
      ST_ADDR:  if (rx_valid && r_cnt == CW'(3)) w_next = r_is_wr ? ST_DATA : ST_TAIL;
      ST_DATA:  if (rx_valid && r_cnt == CW'(DATA_BYTES - 1)) w_next = ST_TAIL;
      ST_TAIL: begin
        if (rx_valid) begin
          w_next = (rx_data == TAIL_BYTE) ? ST_ISSUE : ST_IDLE;
          w_err  = (rx_data != TAIL_BYTE);
        end
      end
      ST_ISSUE: begin
        w_err  = rx_valid;
        w_next = cmd_ready ? ST_IDLE : ST_ISSUE;
      end
      default: w_next = ST_IDLE;
    endcase
    if (w_to) begin
      w_next = ST_IDLE;
      w_err  = 1'b1;
    end
  end
  // State, counters and frame registers; reset discards any partial frame silently
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
      r_err   <= 1'b0;
      r_is_wr <= 1'b0;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      r_err   <= w_err;
      r_gap   <= (rx_valid || !w_frame) ? '0 : r_gap + 32'd1;
      r_cnt   <= (w_next != r_state) ? '0 : (rx_valid && w_frame) ? r_cnt + CW'(1) : r_cnt;
      if (r_state == ST_IDLE && w_next == ST_ADDR) r_is_wr <= (rx_data == OP_WR);
      if (r_state == ST_ADDR && rx_valid) r_addr <= {r_addr[ADDR_WIDTH-9:0], rx_data};
      if (r_state == ST_DATA && rx_valid) r_wdata[8*r_cnt +: 8] <= rx_data;
    end
  end
endmodule

// File: tb/tb_uart_ddr2_cmd_parser.sv
// tb_uart_ddr2_cmd_parser: directed and randomized frames checked against a byte-level command model
module tb_uart_ddr2_cmd_parser;
  localparam int TO = 40;
  typedef logic [7:0] bq_t[$];
  logic         sys_clk = 1'b0;
  logic         sys_rst_n = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_valid = 1'b0;
  logic         cmd_ready = 1'b0;
  logic         cmd_valid;
  logic         cmd_is_wr;
  logic [25:0]  cmd_addr;
  logic [127:0] cmd_wdata;
  logic         frame_err;
  logic         busy;
  int           n_tests = 0;
  int           n_fail = 0;
  int           n_err = 0;
  int           n_cmd = 0;
  int           exp_cmd = 0;
  logic         prev_v = 1'b0;
  logic         exp_wr;
  logic [25:0]  exp_addr;
  logic [127:0] exp_wdata;
  uart_ddr2_cmd_parser #(.TIMEOUT_CYC(TO)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_wr(cmd_is_wr), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .frame_err(frame_err), .busy(busy)
  );
  always #5 sys_clk = ~sys_clk;
  always @(negedge sys_clk) begin
    if (frame_err) n_err++;
    if (cmd_valid && !prev_v) n_cmd++;
    prev_v = cmd_valid;
  end
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input int gap);
    @(negedge sys_clk);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge sys_clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge sys_clk);
  endtask
  task automatic send_q(input bq_t q, input int max_gap);
    foreach (q[i]) send(q[i], (i == q.size() - 1) ? 0 : $urandom_range(max_gap));
  endtask
  task automatic model(input bq_t q);
    exp_wr = (q[0] == 8'h01);
    exp_addr = 26'({q[1], q[2], q[3], q[4]});
    if (exp_wr) for (int k = 0; k < 16; k++) exp_wdata[8*k +: 8] = q[5+k];
  endtask
  function automatic bq_t rand_frame(input bit wr);
    bq_t q;
    q.push_back(wr ? 8'h01 : 8'h02);
    for (int i = 0; i < (wr ? 20 : 4); i++) q.push_back(8'($urandom));
    q.push_back(8'hFF);
    return q;
  endfunction
  task automatic wait_valid(input string tag);
    int c = 0;
    while (!cmd_valid && c < 50) begin
      @(negedge sys_clk);
      c++;
    end
    chk({tag, "_valid"}, cmd_valid, 1);
  endtask
  task automatic check_cmd(input string tag);
    chk({tag, "_is_wr"}, cmd_is_wr, exp_wr);
    chk({tag, "_addr"}, cmd_addr, exp_addr);
    if (exp_wr) chk({tag, "_wdata"}, cmd_wdata, exp_wdata);
  endtask
  task automatic accept(input string tag);
    cmd_ready = 1'b1;
    @(negedge sys_clk);
    chk({tag, "_drop"}, cmd_valid, 0);
    cmd_ready = 1'b0;
    exp_cmd++;
    chk({tag, "_count"}, n_cmd, exp_cmd);
  endtask
  task automatic full_frame(input string tag, input bq_t q, input int max_gap);
    model(q);
    send_q(q, max_gap);
    wait_valid(tag);
    check_cmd(tag);
    repeat ($urandom_range(3)) @(negedge sys_clk);
    chk({tag, "_hold"}, cmd_valid, 1);
    accept(tag);
  endtask
  initial begin
    bq_t q;
    int  e0;
    exp_wdata = '0;
    @(negedge sys_clk);
    chk("rst_outputs", {cmd_valid, cmd_is_wr, cmd_addr, cmd_wdata, frame_err, busy}, 0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
          8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'h11, 8'h22, 8'hFF};
    e0 = n_err;
    cmd_ready = 1'b1;
    send_q(q, 0);
    chk("t1_valid", cmd_valid, 1);
    chk("t1_is_wr", cmd_is_wr, 1);
    chk("t1_addr", cmd_addr, 0);
    chk("t1_wdata", cmd_wdata, 128'h2211EEDDCCBBAA998877665544332211);
    @(negedge sys_clk);
    chk("t1_drop", cmd_valid, 0);
    exp_cmd++;
    chk("t1_count", n_cmd, exp_cmd);
    chk("t1_no_err", n_err, e0);
    cmd_ready = 1'b0;
    q = '{8'h02, 8'h00, 8'h01, 8'h23, 8'h45, 8'hFF};
    send_q(q, 0);
    wait_valid("t2");
    chk("t2_is_wr", cmd_is_wr, 0);
    chk("t2_addr", cmd_addr, 26'h0012345);
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      chk("t2_stall", {cmd_valid, busy, cmd_is_wr, cmd_addr}, {2'b11, 1'b0, 26'h0012345});
    end
    accept("t2");
    chk("t2_idle", busy, 0);
    e0 = n_err;
    q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h10, 8'hFE};
    send_q(q, 1);
    repeat (2) @(negedge sys_clk);
    chk("t3_err", n_err, e0 + 1);
    chk("t3_no_cmd", {cmd_valid, busy}, 0);
    chk("t3_count", n_cmd, exp_cmd);
    full_frame("t3_next", rand_frame(0), 2);
    e0 = n_err;
    q = '{8'h01, 8'h00, 8'h00};
    send_q(q, 0);
    repeat (TO - 2) @(negedge sys_clk);
    chk("t4_still_busy", busy, 1);
    chk("t4_no_early_err", n_err, e0);
    repeat (6) @(negedge sys_clk);
    chk("t4_err", n_err, e0 + 1);
    chk("t4_idle", busy, 0);
    full_frame("t4_next", rand_frame(1), 3);
    e0 = n_err;
    send(8'h55, 2);
    chk("t5_op_err", n_err, e0 + 1);
    chk("t5_op_idle", busy, 0);
    q = rand_frame(0);
    model(q);
    send_q(q, 1);
    wait_valid("t5");
    send(8'h33, 2);
    chk("t5_issue_err", n_err, e0 + 2);
    chk("t5_pending", cmd_valid, 1);
    check_cmd("t5");
    accept("t5");
    e0 = n_err;
    q = rand_frame(1);
    for (int i = 0; i < 15; i++) send(q[i], 0);
    sys_rst_n = 1'b0;
    #1;
    chk("t6_rst_out", {cmd_valid, cmd_is_wr, cmd_addr, cmd_wdata, frame_err, busy}, 0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("t6_no_err", n_err, e0);
    chk("t6_no_cmd", n_cmd, exp_cmd);
    exp_wdata = '0;
    full_frame("t6_next", rand_frame(1), 2);
    for (int i = 0; i < 8; i++) begin
      e0 = n_err;
      full_frame("rand", rand_frame(1'($urandom)), 4);
      chk("rand_no_err", n_err, e0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
